// File: rtl/ysyx_25040111_mem_arbiter_pkg.sv
// Shared types for the N-master memory-request arbiter: FSM encoding,
// policy selectors and the latched request bundle.
package ysyx_25040111_mem_arbiter_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2,
    ARB_ERR  = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  mask;
    logic [7:0]  len;
    logic        rsign;
  } arb_req_t;

endpackage

// File: rtl/ysyx_25040111_mem_arbiter_rr_pick.sv
// Combinational rotating-priority picker: the first requester at or after
// ptr_i wins, wrapping modulo N. With ptr_i tied to 0 it is plain fixed priority.
module ysyx_25040111_rr_pick #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic [N-1:0] hi_mask;
  logic [N-1:0] hi_req;
  logic [N-1:0] sel_vec;

  // Prefer requesters at or above the pointer; otherwise wrap to the full set,
  // then isolate the lowest set bit.
  assign hi_mask = ~((N'(1) << ptr_i) - N'(1));
  assign hi_req  = req_i & hi_mask;
  assign sel_vec = (|hi_req) ? hi_req : req_i;
  assign gnt_o   = sel_vec & (~sel_vec + N'(1));

endmodule

// File: rtl/ysyx_25040111_mem_arbiter.sv
// N-master arbiter onto the single LSU port: grants one master at a time and
// holds the grant for the whole transaction, with a response timeout.
module ysyx_25040111_mem_arbiter
  import ysyx_25040111_mem_arbiter_pkg::*;
#(
  parameter int N_MST    = 2,
  parameter int ARB_MODE = 0,
  parameter int TO_CYC   = 1024
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_MST-1:0]     m_valid,
  output logic [N_MST-1:0]     m_ready,
  input  logic [N_MST-1:0]     m_write,
  input  logic [32*N_MST-1:0]  m_addr,
  input  logic [32*N_MST-1:0]  m_wdata,
  input  logic [2*N_MST-1:0]   m_mask,
  input  logic [8*N_MST-1:0]   m_len,
  input  logic [N_MST-1:0]     m_rsign,
  output logic [N_MST-1:0]     m_rvalid,
  input  logic [N_MST-1:0]     m_rready,
  output logic [31:0]          m_rdata,
  output logic                 m_rlast,
  output logic                 m_rerr,
  output logic                 s_valid,
  input  logic                 s_ready,
  output logic                 s_write,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [1:0]           s_mask,
  output logic [7:0]           s_len,
  output logic                 s_rsign,
  input  logic                 s_rvalid,
  output logic                 s_rready,
  input  logic [31:0]          s_rdata,
  input  logic                 s_rlast,
  input  logic                 s_rerr
);

  localparam int PW = (N_MST > 1) ? $clog2(N_MST) : 1;

  arb_state_e       state_q, state_d;
  logic [N_MST-1:0] grant_q, grant_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]       beats_q, beats_d;
  logic [31:0]      to_cnt_q, to_cnt_d;
  arb_req_t         req_q, req_d;

  logic [N_MST-1:0] pick;
  logic [PW-1:0]    pick_ptr;
  logic [PW-1:0]    gidx;
  logic [PW-1:0]    ptr_next;
  arb_req_t         win_req;
  logic             own_rready;
  logic             to_hit;

  assign pick_ptr = (ARB_MODE == ARB_RR) ? rr_ptr_q : '0;

  ysyx_25040111_rr_pick #(
    .N  (N_MST),
    .PW (PW)
  ) u_pick (
    .req_i (m_valid),
    .ptr_i (pick_ptr),
    .gnt_o (pick)
  );

  always_comb begin
    win_req = '0;
    gidx    = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (pick[i]) begin
        win_req.write = m_write[i];
        win_req.addr  = m_addr[32*i +: 32];
        win_req.wdata = m_wdata[32*i +: 32];
        win_req.mask  = m_mask[2*i +: 2];
        win_req.len   = m_len[8*i +: 8];
        win_req.rsign = m_rsign[i];
      end
      if (grant_q[i]) gidx = PW'(i);
    end
  end

  assign ptr_next   = (gidx == PW'(N_MST - 1)) ? '0 : gidx + PW'(1);
  assign own_rready = |(grant_q & m_rready);
  // Fires on the TO_CYC-th consecutive RESP cycle without a downstream beat.
  assign to_hit     = (TO_CYC != 0) && !s_rvalid && (to_cnt_q == 32'(TO_CYC - 1));

  assign s_write = req_q.write;
  assign s_addr  = req_q.addr;
  assign s_wdata = req_q.wdata;
  assign s_mask  = req_q.mask;
  assign s_len   = req_q.len;
  assign s_rsign = req_q.rsign;

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    beats_d  = beats_q;
    to_cnt_d = to_cnt_q;
    req_d    = req_q;
    m_ready  = '0;
    m_rvalid = '0;
    m_rdata  = '0;
    m_rlast  = 1'b0;
    m_rerr   = 1'b0;
    s_valid  = 1'b0;
    s_rready = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (|m_valid) begin
          grant_d = pick;
          req_d   = win_req;
          state_d = ARB_REQ;
        end
      end
      ARB_REQ: begin
        s_valid = 1'b1;
        if (s_ready) begin
          m_ready  = grant_q;
          beats_d  = req_q.write ? 8'd0 : req_q.len;
          to_cnt_d = '0;
          state_d  = ARB_RESP;
        end
      end
      ARB_RESP: begin
        s_rready = own_rready;
        m_rvalid = grant_q & {N_MST{s_rvalid}};
        m_rdata  = s_rdata;
        m_rlast  = s_rlast | (beats_q == 8'd0) | s_rerr;
        m_rerr   = s_rerr;
        to_cnt_d = s_rvalid ? '0 : to_cnt_q + 32'd1;
        // A downstream error terminates the burst early on that beat.
        if (s_rvalid && own_rready) begin
          if (beats_q == 8'd0 || s_rerr) begin
            state_d = ARB_IDLE;
            grant_d = '0;
            if (ARB_MODE == ARB_RR) rr_ptr_d = ptr_next;
          end else begin
            beats_d = beats_q - 8'd1;
          end
        end else if (to_hit) begin
          state_d = ARB_ERR;
        end
      end
      ARB_ERR: begin
        m_rvalid = grant_q;
        m_rlast  = 1'b1;
        m_rerr   = 1'b1;
        if (own_rready) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          if (ARB_MODE == ARB_RR) rr_ptr_d = ptr_next;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      beats_q  <= '0;
      to_cnt_q <= '0;
      req_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      beats_q  <= beats_d;
      to_cnt_q <= to_cnt_d;
      req_q    <= req_d;
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_mem_arbiter.sv
// Scoreboard bench: two arbiter instances (fixed N=2, round-robin N=3) share
// stimulus; a negedge monitor pops expected grants, requests and responses.
module tb_ysyx_25040111_mem_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        write;
    logic [1:0]  mask;
    logic [7:0]  len;
    logic        rsign;
  } reqExp_t;

  typedef struct {
    int          mst;
    logic [31:0] data;
    logic        last;
    logic        err;
  } respExp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  int          sel = 0;

  logic [2:0]  mValid = '0;
  logic [2:0]  mWrite = '0;
  logic [95:0] mAddr = '0;
  logic [95:0] mWdata = '0;
  logic [5:0]  mMask = '0;
  logic [23:0] mLen = '0;
  logic [2:0]  mRsign = '0;
  logic [2:0]  mRready = 3'b111;
  logic        sReady = 1'b0;
  logic        sRvalid = 1'b0;
  logic [31:0] sRdata = '0;
  logic        sRlast = 1'b0;
  logic        sRerr = 1'b0;

  logic [1:0]  fValid;
  logic [2:0]  rValid;

  logic [1:0]  fMReady, fMRvalid;
  logic [31:0] fMRdata, fSAddr, fSWdata;
  logic        fMRlast, fMRerr, fSValid, fSWrite, fSRsign, fSRready;
  logic [1:0]  fSMask;
  logic [7:0]  fSLen;

  logic [2:0]  rMReady, rMRvalid;
  logic [31:0] rMRdata, rSAddr, rSWdata;
  logic        rMRlast, rMRerr, rSValid, rSWrite, rSRsign, rSRready;
  logic [1:0]  rSMask;
  logic [7:0]  rSLen;

  logic [2:0]  curMReady, curMRvalid;
  logic [31:0] curMRdata, curSAddr, curSWdata;
  logic        curMRlast, curMRerr, curSValid, curSWrite, curSRsign, curSRready;
  logic [1:0]  curSMask;
  logic [7:0]  curSLen;

  int          compared = 0;
  int          mismatched = 0;
  reqExp_t     reqQ[$];
  int          grantQ[$];
  respExp_t    respQ[$];

  assign fValid = (sel == 0) ? mValid[1:0] : 2'b00;
  assign rValid = (sel == 1) ? mValid : 3'b000;

  ysyx_25040111_mem_arbiter #(.N_MST(2), .ARB_MODE(0), .TO_CYC(16)) dutF (
    .clock(clock), .reset(reset),
    .m_valid(fValid), .m_ready(fMReady), .m_write(mWrite[1:0]),
    .m_addr(mAddr[63:0]), .m_wdata(mWdata[63:0]), .m_mask(mMask[3:0]),
    .m_len(mLen[15:0]), .m_rsign(mRsign[1:0]),
    .m_rvalid(fMRvalid), .m_rready(mRready[1:0]), .m_rdata(fMRdata),
    .m_rlast(fMRlast), .m_rerr(fMRerr),
    .s_valid(fSValid), .s_ready(sReady), .s_write(fSWrite), .s_addr(fSAddr),
    .s_wdata(fSWdata), .s_mask(fSMask), .s_len(fSLen), .s_rsign(fSRsign),
    .s_rvalid(sRvalid), .s_rready(fSRready), .s_rdata(sRdata),
    .s_rlast(sRlast), .s_rerr(sRerr)
  );

  ysyx_25040111_mem_arbiter #(.N_MST(3), .ARB_MODE(1), .TO_CYC(16)) dutR (
    .clock(clock), .reset(reset),
    .m_valid(rValid), .m_ready(rMReady), .m_write(mWrite),
    .m_addr(mAddr), .m_wdata(mWdata), .m_mask(mMask),
    .m_len(mLen), .m_rsign(mRsign),
    .m_rvalid(rMRvalid), .m_rready(mRready), .m_rdata(rMRdata),
    .m_rlast(rMRlast), .m_rerr(rMRerr),
    .s_valid(rSValid), .s_ready(sReady), .s_write(rSWrite), .s_addr(rSAddr),
    .s_wdata(rSWdata), .s_mask(rSMask), .s_len(rSLen), .s_rsign(rSRsign),
    .s_rvalid(sRvalid), .s_rready(rSRready), .s_rdata(sRdata),
    .s_rlast(sRlast), .s_rerr(sRerr)
  );

  always #5 clock = ~clock;

  // View of whichever instance is currently being exercised
  always_comb begin
    if (sel == 0) begin
      curMReady  = {1'b0, fMReady};
      curMRvalid = {1'b0, fMRvalid};
      curMRdata  = fMRdata;
      curMRlast  = fMRlast;
      curMRerr   = fMRerr;
      curSValid  = fSValid;
      curSWrite  = fSWrite;
      curSAddr   = fSAddr;
      curSWdata  = fSWdata;
      curSMask   = fSMask;
      curSLen    = fSLen;
      curSRsign  = fSRsign;
      curSRready = fSRready;
    end else begin
      curMReady  = rMReady;
      curMRvalid = rMRvalid;
      curMRdata  = rMRdata;
      curMRlast  = rMRlast;
      curMRerr   = rMRerr;
      curSValid  = rSValid;
      curSWrite  = rSWrite;
      curSAddr   = rSAddr;
      curSWdata  = rSWdata;
      curSMask   = rSMask;
      curSLen    = rSLen;
      curSRsign  = rSRsign;
      curSRready = rSRready;
    end
  end

  function automatic int ohIdx(input logic [2:0] v);
    int idx = -1;
    int cnt = 0;
    for (int i = 0; i < 3; i++) begin
      if (v[i]) begin
        idx = i;
        cnt++;
      end
    end
    if (cnt > 1) idx = 9;
    return idx;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic reportMiss(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: got no/unexpected DUT event, expected a matching one", name);
  endtask

  task automatic applyStimulus(input int mst, input logic write, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [1:0] mask,
                               input logic [7:0] len, input logic rsign);
    mWrite[mst]          = write;
    mAddr[32*mst +: 32]  = addr;
    mWdata[32*mst +: 32] = wdata;
    mMask[2*mst +: 2]    = mask;
    mLen[8*mst +: 8]     = len;
    mRsign[mst]          = rsign;
    mValid[mst]          = 1'b1;
  endtask

  // Queue the grant, the downstream request and nBeats responses for one transaction.
  task automatic expectTxn(input int mst, input logic write, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] mask,
                           input logic [7:0] len, input logic rsign,
                           input int nBeats, input int errBeat, input logic [31:0] dataBase);
    reqExp_t  re;
    respExp_t rs;
    re = '{addr: addr, wdata: wdata, write: write, mask: mask, len: len, rsign: rsign};
    reqQ.push_back(re);
    grantQ.push_back(mst);
    for (int b = 0; b < nBeats; b++) begin
      rs.mst  = mst;
      rs.data = dataBase + 32'(b);
      rs.last = (b == nBeats - 1) || (b == errBeat);
      rs.err  = (b == errBeat);
      respQ.push_back(rs);
      if (b == errBeat) break;
    end
  endtask

  // Downstream model: accept the request, then return nBeats beats back to back.
  task automatic serveTxn(input int mst, input int nBeats, input int errBeat,
                          input bit driveLast, input int clrMode, input logic [31:0] dataBase);
    int waitCnt = 0;
    while (!curSValid && waitCnt < 20) begin
      tick();
      waitCnt++;
    end
    if (!curSValid) begin
      reportMiss("sValidWait");
      return;
    end
    sReady = 1'b1;
    tick();
    sReady = 1'b0;
    if (clrMode == 0) mValid[mst] = 1'b0;
    else if (clrMode == 2) mValid = '0;
    for (int b = 0; b < nBeats; b++) begin
      sRvalid = 1'b1;
      sRdata  = dataBase + 32'(b);
      sRlast  = driveLast && (b == nBeats - 1);
      sRerr   = (b == errBeat);
      tick();
      sRvalid = 1'b0;
      sRlast  = 1'b0;
      sRerr   = 1'b0;
      if (b == errBeat) break;
    end
  endtask

  // Monitor: every request accept, grant pulse and response handshake pops an expectation
  always @(negedge clock) begin
    reqExp_t  re;
    respExp_t rs;
    int       gi;
    if (reset) begin
      if (curSValid && sReady) begin
        if (reqQ.size() == 0) reportMiss("reqUnexpected");
        else begin
          re = reqQ.pop_front();
          checkOutput("reqAddr", curSAddr, re.addr);
          checkOutput("reqWrite", 32'(curSWrite), 32'(re.write));
          checkOutput("reqMask", 32'(curSMask), 32'(re.mask));
          checkOutput("reqLen", 32'(curSLen), 32'(re.len));
          checkOutput("reqRsign", 32'(curSRsign), 32'(re.rsign));
          if (re.write) checkOutput("reqWdata", curSWdata, re.wdata);
        end
      end
      if (curMReady != 3'b000) begin
        if (grantQ.size() == 0) reportMiss("grantUnexpected");
        else begin
          gi = grantQ.pop_front();
          checkOutput("grant", 32'(ohIdx(curMReady)), 32'(gi));
        end
      end
      if ((curMRvalid & mRready) != 3'b000) begin
        if (respQ.size() == 0) reportMiss("respUnexpected");
        else begin
          rs = respQ.pop_front();
          checkOutput("respMst", 32'(ohIdx(curMRvalid)), 32'(rs.mst));
          checkOutput("respData", curMRdata, rs.data);
          checkOutput("respLast", 32'(curMRlast), 32'(rs.last));
          checkOutput("respErr", 32'(curMRerr), 32'(rs.err));
        end
      end
    end
  end

  initial begin
    int lat;

    // Reset values of both instances
    repeat (3) tick();
    checkOutput("rstMReadyF", 32'(fMReady), 32'd0);
    checkOutput("rstRvalidF", 32'(fMRvalid), 32'd0);
    checkOutput("rstSValidF", 32'(fSValid), 32'd0);
    checkOutput("rstSRreadyF", 32'(fSRready), 32'd0);
    checkOutput("rstMReadyR", 32'(rMReady), 32'd0);
    checkOutput("rstRvalidR", 32'(rMRvalid), 32'd0);
    checkOutput("rstSValidR", 32'(rSValid), 32'd0);
    checkOutput("rstSRreadyR", 32'(rSRready), 32'd0);
    reset = 1'b1;
    tick();

    $display("[TB] fixed priority: simultaneous read (m0) and write (m1)");
    applyStimulus(0, 1'b0, 32'h0000_1000, 32'h0, 2'd2, 8'd0, 1'b0);
    applyStimulus(1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 2'd2, 8'd5, 1'b0);
    expectTxn(0, 1'b0, 32'h0000_1000, 32'h0, 2'd2, 8'd0, 1'b0, 1, -1, 32'hAAAA_0000);
    expectTxn(1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 2'd2, 8'd5, 1'b0, 1, -1, 32'h0);
    serveTxn(0, 1, -1, 1'b1, 0, 32'hAAAA_0000);
    serveTxn(1, 1, -1, 1'b0, 0, 32'h0);
    tick();

    $display("[TB] fixed priority: 4-beat burst with m1 waiting");
    applyStimulus(0, 1'b0, 32'h0000_3000, 32'h0, 2'd2, 8'd3, 1'b1);
    applyStimulus(1, 1'b0, 32'h0000_4000, 32'h0, 2'd1, 8'd0, 1'b0);
    expectTxn(0, 1'b0, 32'h0000_3000, 32'h0, 2'd2, 8'd3, 1'b1, 4, -1, 32'hB000_0000);
    expectTxn(1, 1'b0, 32'h0000_4000, 32'h0, 2'd1, 8'd0, 1'b0, 1, -1, 32'hC000_0000);
    serveTxn(0, 4, -1, 1'b0, 0, 32'hB000_0000);
    serveTxn(1, 1, -1, 1'b1, 0, 32'hC000_0000);
    tick();

    $display("[TB] fixed priority: downstream error on beat 2 of 4");
    applyStimulus(1, 1'b0, 32'h0000_5000, 32'h0, 2'd2, 8'd3, 1'b0);
    expectTxn(1, 1'b0, 32'h0000_5000, 32'h0, 2'd2, 8'd3, 1'b0, 4, 1, 32'hD000_0000);
    serveTxn(1, 4, 1, 1'b1, 0, 32'hD000_0000);
    applyStimulus(0, 1'b0, 32'h0000_6000, 32'h0, 2'd0, 8'd0, 1'b0);
    expectTxn(0, 1'b0, 32'h0000_6000, 32'h0, 2'd0, 8'd0, 1'b0, 1, -1, 32'hE000_0000);
    serveTxn(0, 1, -1, 1'b1, 0, 32'hE000_0000);
    tick();

    $display("[TB] fixed priority: response timeout");
    mRready = 3'b000;
    applyStimulus(0, 1'b0, 32'h0000_7000, 32'h0, 2'd2, 8'd0, 1'b0);
    expectTxn(0, 1'b0, 32'h0000_7000, 32'h0, 2'd2, 8'd0, 1'b0, 0, -1, 32'h0);
    respQ.push_back('{mst: 0, data: 32'h0, last: 1'b1, err: 1'b1});
    serveTxn(0, 0, -1, 1'b0, 0, 32'h0);
    lat = 0;
    while (curMRvalid == 3'b000 && lat < 40) begin
      tick();
      lat++;
    end
    checkOutput("toLatency", 32'(lat), 32'd16);
    tick();
    tick();
    checkOutput("errHold", 32'(curMRvalid), 32'd1);
    mRready = 3'b111;
    tick();
    tick();
    checkOutput("idleAfterErr", 32'(curMRvalid), 32'd0);

    sel = 1;
    tick();
    $display("[TB] round robin: three masters requesting continuously");
    applyStimulus(0, 1'b0, 32'h0000_8000, 32'h0, 2'd2, 8'd0, 1'b0);
    applyStimulus(1, 1'b0, 32'h0000_9000, 32'h0, 2'd2, 8'd0, 1'b0);
    applyStimulus(2, 1'b0, 32'h0000_A000, 32'h0, 2'd2, 8'd0, 1'b0);
    expectTxn(0, 1'b0, 32'h0000_8000, 32'h0, 2'd2, 8'd0, 1'b0, 1, -1, 32'h1000_0000);
    expectTxn(1, 1'b0, 32'h0000_9000, 32'h0, 2'd2, 8'd0, 1'b0, 1, -1, 32'h1100_0000);
    expectTxn(2, 1'b0, 32'h0000_A000, 32'h0, 2'd2, 8'd0, 1'b0, 1, -1, 32'h1200_0000);
    expectTxn(0, 1'b0, 32'h0000_8000, 32'h0, 2'd2, 8'd0, 1'b0, 1, -1, 32'h1300_0000);
    serveTxn(0, 1, -1, 1'b1, 1, 32'h1000_0000);
    serveTxn(1, 1, -1, 1'b1, 1, 32'h1100_0000);
    serveTxn(2, 1, -1, 1'b1, 1, 32'h1200_0000);
    serveTxn(0, 1, -1, 1'b1, 2, 32'h1300_0000);
    tick();

    $display("[TB] round robin: reset during a response");
    applyStimulus(1, 1'b1, 32'h0000_B000, 32'h1234_5678, 2'd0, 8'd0, 1'b0);
    expectTxn(1, 1'b1, 32'h0000_B000, 32'h1234_5678, 2'd0, 8'd0, 1'b0, 1, -1, 32'h0);
    serveTxn(1, 1, -1, 1'b1, 0, 32'h0);
    applyStimulus(2, 1'b0, 32'h0000_C000, 32'h0, 2'd2, 8'd2, 1'b0);
    expectTxn(2, 1'b0, 32'h0000_C000, 32'h0, 2'd2, 8'd2, 1'b0, 0, -1, 32'h0);
    serveTxn(2, 0, -1, 1'b0, 0, 32'h0);
    mRready = 3'b000;
    sRvalid = 1'b1;
    sRdata  = 32'h0000_0055;
    #2;
    checkOutput("rvalidPreRst", 32'(curMRvalid), 32'd4);
    reset = 1'b0;
    #1;
    checkOutput("rstMidMReady", 32'(curMReady), 32'd0);
    checkOutput("rstMidRvalid", 32'(curMRvalid), 32'd0);
    checkOutput("rstMidSValid", 32'(curSValid), 32'd0);
    checkOutput("rstMidSRready", 32'(curSRready), 32'd0);
    sRvalid = 1'b0;
    tick();
    reset   = 1'b1;
    mRready = 3'b111;
    tick();
    checkOutput("idleAfterRst", 32'(curSValid), 32'd0);
    applyStimulus(1, 1'b0, 32'h0000_D000, 32'h0, 2'd2, 8'd0, 1'b0);
    applyStimulus(2, 1'b0, 32'h0000_E000, 32'h0, 2'd2, 8'd0, 1'b0);
    expectTxn(1, 1'b0, 32'h0000_D000, 32'h0, 2'd2, 8'd0, 1'b0, 1, -1, 32'h2000_0000);
    expectTxn(2, 1'b0, 32'h0000_E000, 32'h0, 2'd2, 8'd0, 1'b0, 1, -1, 32'h2100_0000);
    serveTxn(1, 1, -1, 1'b1, 0, 32'h2000_0000);
    serveTxn(2, 1, -1, 1'b1, 0, 32'h2100_0000);

    repeat (3) tick();
    checkOutput("reqQLeft", 32'(reqQ.size()), 32'd0);
    checkOutput("grantQLeft", 32'(grantQ.size()), 32'd0);
    checkOutput("respQLeft", 32'(respQ.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
